// File: rtl/fft_reorder_out_buffer.sv
// Ping-pong reorder buffer after the last FFT stage: lanes are scaled and written in natural bin
// order into one of two banks, then streamed one sample per cycle under valid/ready.
module fft_reorder_out_buffer #(
    parameter int NPTS  = 256,
    parameter int LANES = 8,
    parameter int IN_W  = 30,
    parameter int OUT_W = 20,
    parameter int SHIFT = 10,
    parameter int ROUND = 0,
    parameter int AW    = $clog2(NPTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [LANES*IN_W-1:0]  in_real,
    input  logic [LANES*IN_W-1:0]  in_imag,
    input  logic                   out_ready,
    input  logic                   clear_flags,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_real,
    output logic [OUT_W-1:0]       out_imag,
    output logic [AW-1:0]          out_index,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   overflow,
    output logic                   sat_flag
);

    // Handshake: a sample transfers on a rising edge where out_valid=1 and out_ready=1;
    // while out_valid=1 and out_ready=0 every output holds its value.

    localparam int BEATS = NPTS / LANES;
    localparam int CW    = $clog2(BEATS);
    localparam int LSH   = $clog2(LANES) - 1;
    localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W:0] RND  = (ROUND != 0 && SHIFT > 0) ? ((IN_W+1)'(1) << RSH) : (IN_W+1)'(0);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((64'(1) << (OUT_W-1)) - 64'(1));
    localparam logic signed [IN_W:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;

    // Returns {saturated, scaled value}.
    function automatic logic [OUT_W:0] scale(input logic [IN_W-1:0] x);
        logic signed [IN_W:0] s;
        s = ($signed({x[IN_W-1], x}) + RND) >>> SHIFT;
        if (s > MAXV)      scale = {1'b1, MAXV[OUT_W-1:0]};
        else if (s < MINV) scale = {1'b1, MINV[OUT_W-1:0]};
        else               scale = {1'b0, s[OUT_W-1:0]};
    endfunction

    // Even lanes fill the lower half of the spectrum, odd lanes the upper half.
    function automatic logic [AW-1:0] lane_addr(input int l, input logic [CW-1:0] c);
        lane_addr = AW'(l >> 1) + (((l & 1) != 0) ? AW'(NPTS/2) : AW'(0)) + (AW'(c) << LSH);
    endfunction

    logic [2*OUT_W-1:0] mem [2][NPTS];

    wr_state_t          state;
    logic [CW-1:0]      cnt;
    logic               cur_bank;
    logic [1:0]         full;
    logic               q0, q1;
    logic [1:0]         qcnt;
    logic [AW-1:0]      rd_idx;
    logic               out_bank;

    logic [OUT_W:0]     sc_re [LANES];
    logic [OUT_W:0]     sc_im [LANES];
    logic [2*OUT_W-1:0] lane_word [LANES];
    logic [LANES-1:0]   lane_sat;

    logic       free_now, sel_bank, start, wr_en, wr_bank, done, ld, pop;
    logic [1:0] avail, full_n, q_mid;
    logic [CW-1:0] wr_c;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sc_re[l]     = scale(in_real[l*IN_W +: IN_W]);
            sc_im[l]     = scale(in_imag[l*IN_W +: IN_W]);
            lane_word[l] = {sc_im[l][OUT_W-1:0], sc_re[l][OUT_W-1:0]};
            lane_sat[l]  = sc_re[l][OUT_W] | sc_im[l][OUT_W];
        end
    end

    always_comb begin
        free_now = out_valid && out_ready && out_eof;
        avail    = ~full;
        if (free_now) avail[out_bank] = 1'b1;
        sel_bank = avail[0] ? 1'b0 : 1'b1;
        start    = in_valid && in_sof && (state != FILL);
        wr_en    = (start && (avail != 2'b00)) || (state == FILL && in_valid);
        wr_bank  = (state == FILL) ? cur_bank : sel_bank;
        wr_c     = in_sof ? '0 : cnt;
        done     = (state == FILL) && in_valid && !in_sof && (cnt == CW'(BEATS-1));
        full_n   = full;
        if (free_now) full_n[out_bank] = 1'b0;
        if (done)     full_n[cur_bank] = 1'b1;
        ld       = (!out_valid || out_ready) && (qcnt != 2'd0);
        pop      = ld && (rd_idx == AW'(NPTS-1));
        q_mid    = qcnt - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                mem[wr_bank][lane_addr(l, wr_c)] <= lane_word[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_bank  <= 1'b0;
            full      <= 2'b00;
            q0        <= 1'b0;
            q1        <= 1'b0;
            qcnt      <= 2'd0;
            rd_idx    <= '0;
            out_bank  <= 1'b0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            overflow  <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE, DROP: begin
                    if (start) begin
                        if (avail != 2'b00) begin
                            cur_bank <= sel_bank;
                            cnt      <= CW'(1);
                            state    <= FILL;
                        end else begin
                            state    <= DROP;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            cnt <= CW'(1);
                        end else if (done) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            full <= full_n;

            // q0 is the oldest filled bank whose samples are not all loaded yet.
            if (pop) q0 <= q1;
            if (done) begin
                if (q_mid == 2'd0) q0 <= cur_bank;
                else               q1 <= cur_bank;
            end
            qcnt <= q_mid + (done ? 2'd1 : 2'd0);

            if (ld) begin
                out_valid               <= 1'b1;
                {out_imag, out_real}    <= mem[q0][rd_idx];
                out_index               <= rd_idx;
                out_sof                 <= (rd_idx == '0);
                out_eof                 <= (rd_idx == AW'(NPTS-1));
                out_bank                <= q0;
                rd_idx                  <= rd_idx + AW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (start && (avail == 2'b00)) overflow <= 1'b1;
            else if (clear_flags)          overflow <= 1'b0;

            if (wr_en && (lane_sat != '0)) sat_flag <= 1'b1;
            else if (clear_flags)          sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_reorder_out_buffer.sv
// Directed bench for fft_reorder_out_buffer: a default-parameter instance checked through a
// sample scoreboard, plus a tiny rounding/saturating instance checked against hand vectors.
module tb_fft_reorder_out_buffer;

    localparam int W = 8 + 1 + 1 + 20 + 20;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic         in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1, clear_flags = 1'b0;
    logic [239:0] in_real = '0, in_imag = '0;
    logic         out_valid, out_sof, out_eof, overflow, sat_flag;
    logic [19:0]  out_real, out_imag;
    logic [7:0]   out_index;

    fft_reorder_out_buffer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_real(in_real), .in_imag(in_imag), .out_ready(out_ready), .clear_flags(clear_flags),
        .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
        .out_sof(out_sof), .out_eof(out_eof), .overflow(overflow), .sat_flag(sat_flag)
    );

    // small rounding/saturating instance
    logic        s_in_valid = 1'b0, s_in_sof = 1'b0, s_clear_flags = 1'b0, s_out_ready = 1'b1;
    logic [23:0] s_in_real = '0, s_in_imag = '0;
    logic        s_out_valid, s_out_sof, s_out_eof, s_overflow, s_sat_flag;
    logic [7:0]  s_out_real, s_out_imag;
    logic [1:0]  s_out_index;

    fft_reorder_out_buffer #(.NPTS(4), .LANES(2), .IN_W(12), .OUT_W(8), .SHIFT(2), .ROUND(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_sof(s_in_sof),
        .in_real(s_in_real), .in_imag(s_in_imag), .out_ready(s_out_ready), .clear_flags(s_clear_flags),
        .out_valid(s_out_valid), .out_real(s_out_real), .out_imag(s_out_imag), .out_index(s_out_index),
        .out_sof(s_out_sof), .out_eof(s_out_eof), .overflow(s_overflow), .sat_flag(s_sat_flag)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur, held, exp_v;
    logic         mon_en = 1'b0, stall_pend = 1'b0, rnd_rdy = 1'b0;
    int           acc_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;

    assign cur = {out_index, out_sof, out_eof, out_imag, out_real};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_pend) check("stall_hold", {out_valid, cur}, {1'b1, held});
            if (out_valid && out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("sample", cur, exp_v);
                if (acc_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                acc_cnt++;
                stall_pend = 1'b0;
            end else if (out_valid) begin
                stall_pend = 1'b1;
                held = cur;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    // frame data indexed by frequency bin
    logic [29:0] in_re [256];
    logic [29:0] in_im [256];
    logic [19:0] ex_re [256];
    logic [19:0] ex_im [256];

    task automatic build_frame(input int tag);
        logic [19:0] re;
        for (int b = 0; b < 256; b++) begin
            re = 20'(tag * 256 + b);
            in_re[b] = {re, 10'($urandom_range(0, 1023))};
            in_im[b] = {~re, 10'($urandom_range(0, 1023))};
            ex_re[b] = re;
            ex_im[b] = ~re;
        end
    endtask

    task automatic push_exp();
        for (int b = 0; b < 256; b++)
            exp_q.push_back({8'(b), (b == 0), (b == 255), ex_im[b], ex_re[b]});
    endtask

    task automatic drive_beat(input int c, input bit sof);
        int b;
        in_valid = 1'b1;
        in_sof   = sof;
        for (int l = 0; l < 8; l++) begin
            b = (l >> 1) + (l & 1) * 128 + 4 * c;
            in_real[l*30 +: 30] = in_re[b];
            in_imag[l*30 +: 30] = in_im[b];
        end
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drive_frame();
        for (int c = 0; c < 32; c++) drive_beat(c, c == 0);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int k = 0;
        while (acc_cnt < target && k < budget) begin
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        check("wait_acc", 64'(acc_cnt), 64'(target));
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        s_clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        s_clear_flags = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_init", {out_valid, out_real, out_imag, out_index, out_sof, out_eof, overflow, sat_flag}, '0);
        reset = 1'b1;
        mon_en = 1'b1;

        // single frame, latency and natural order
        acc_cnt = 0;
        build_frame(0);
        push_exp();
        drive_frame();
        check("lat_T", out_valid, 0);
        @(posedge clk); #1;
        check("lat_T1", {out_valid, out_sof, out_index}, {1'b1, 1'b1, 8'd0});
        wait_acc(256, 1000);

        // back-to-back frames stream without bubbles
        acc_cnt = 0;
        build_frame(1);
        push_exp();
        drive_frame();
        build_frame(2);
        push_exp();
        drive_frame();
        wait_acc(512, 2000);
        check("gapless_span", 64'(last_cyc - first_cyc), 64'd511);
        check("no_overflow", overflow, 0);

        // three frames while stalled: third dropped
        acc_cnt = 0;
        out_ready = 1'b0;
        build_frame(3); push_exp(); drive_frame();
        build_frame(4); push_exp(); drive_frame();
        check("ovf_before_drop", overflow, 0);
        build_frame(5); drive_frame();
        check("ovf_set", overflow, 1);
        check("stall_head", {out_valid, out_index, out_real}, {1'b1, 8'd0, 20'(3 * 256)});
        out_ready = 1'b1;
        wait_acc(512, 2000);
        check("ovf_sticky", overflow, 1);
        pulse_clear();
        check("ovf_cleared", overflow, 0);

        // range extremes with random backpressure
        acc_cnt = 0;
        build_frame(6);
        in_re[0] = 30'h1FFFFFFF; ex_re[0] = 20'h7FFFF;
        in_re[1] = 30'h20000000; ex_re[1] = 20'h80000;
        in_im[2] = 30'h3FFFFFFF; ex_im[2] = 20'hFFFFF;
        push_exp();
        rnd_rdy = 1'b1;
        drive_frame();
        wait_acc(256, 4000);
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        check("sat_default_none", sat_flag, 0);

        // rounding and saturation on the small instance
        check("s_sat_pre", s_sat_flag, 0);
        s_in_valid = 1'b1; s_in_sof = 1'b1;
        s_in_real = {12'h800, 12'h002}; s_in_imag = {12'h001, 12'h006};
        @(posedge clk); #1;
        s_in_sof = 1'b0;
        s_in_real = {12'hFFD, 12'h7FF}; s_in_imag = {12'h000, 12'h005};
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("s_lat_T", s_out_valid, 0);
        check("s_sat_set", s_sat_flag, 1);
        @(posedge clk); #1;
        check("s_bin0", {s_out_valid, s_out_index, s_out_sof, s_out_eof, s_out_imag, s_out_real}, {1'b1, 2'd0, 1'b1, 1'b0, 8'h02, 8'h01});
        @(posedge clk); #1;
        check("s_bin1", {s_out_valid, s_out_index, s_out_sof, s_out_eof, s_out_imag, s_out_real}, {1'b1, 2'd1, 1'b0, 1'b0, 8'h01, 8'h7F});
        @(posedge clk); #1;
        check("s_bin2", {s_out_valid, s_out_index, s_out_sof, s_out_eof, s_out_imag, s_out_real}, {1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h80});
        @(posedge clk); #1;
        check("s_bin3", {s_out_valid, s_out_index, s_out_sof, s_out_eof, s_out_imag, s_out_real}, {1'b1, 2'd3, 1'b0, 1'b1, 8'h00, 8'hFF});
        pulse_clear();
        check("s_drained", s_out_valid, 0);
        check("s_sat_cleared", s_sat_flag, 0);

        // reset in the middle of a fill
        build_frame(7);
        for (int c = 0; c < 10; c++) drive_beat(c, c == 0);
        mon_en = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_fill", {out_valid, out_real, out_imag, out_index, out_sof, out_eof, overflow, sat_flag}, '0);
        reset = 1'b1;

        // reset in the middle of a read
        stall_pend = 1'b0;
        mon_en = 1'b1;
        acc_cnt = 0;
        build_frame(8); push_exp(); drive_frame();
        wait_acc(50, 500);
        mon_en = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_read", {out_valid, out_real, out_imag, out_index, out_sof, out_eof, overflow, sat_flag}, '0);
        reset = 1'b1;
        exp_q.delete();
        stall_pend = 1'b0;

        // fresh frame after reset
        mon_en = 1'b1;
        acc_cnt = 0;
        build_frame(9); push_exp(); drive_frame();
        wait_acc(256, 1000);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
